// File: rtl/coeff_token_sched.sv
// coeff_token scheduler: picks the nC table, launches one lookup per residual block,
// issues a single consume pulse to the bit buffer and hands the token downstream.
module coeff_token_sched #(
    parameter int unsigned STALL_MAX = 255,
    parameter int unsigned MIN_BITS  = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        BlkValid,
    output logic        BlkReady,
    input  logic [4:0]  NC,
    input  logic        ChromaDC,
    input  logic [15:0] Window,
    input  logic [5:0]  BitsAvail,
    output logic [2:0]  LutSel,
    output logic [15:0] LutBits,
    input  logic [4:0]  LutTotalCoeff,
    input  logic [1:0]  LutTrailingOnes,
    input  logic [4:0]  LutNumShift,
    output logic        ShiftValid,
    output logic [4:0]  ShiftAmt,
    output logic        TokValid,
    input  logic        TokReady,
    output logic [4:0]  TotalCoeff,
    output logic [1:0]  TrailingOnes,
    output logic        TokErr
);

    localparam int CW = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_MAX - 1);
    localparam logic [5:0]    MIN_AVAIL  = 6'(MIN_BITS);

    typedef enum logic [2:0] {IDLE, FILL, LOOKUP, SHIFT, EMIT} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  stall_cnt, cnt_d;
    logic [5:0]     bits_cap, cap_d;
    logic [2:0]     sel_d, sel_new;
    logic [15:0]    bits_d;
    logic [4:0]     tc_d, amt_d, nc_sat, tc_max;
    logic [1:0]     t1_d;
    logic           err_d, lut_bad;

    // nC above 16 selects the same table as 16; chroma DC overrides nC entirely
    always_comb begin
        nc_sat = (NC > 5'd16) ? 5'd16 : NC;
        if (ChromaDC)              sel_new = 3'd4;
        else if (nc_sat < 5'd2)    sel_new = 3'd0;
        else if (nc_sat < 5'd4)    sel_new = 3'd1;
        else if (nc_sat < 5'd8)    sel_new = 3'd2;
        else                       sel_new = 3'd3;
    end

    assign tc_max  = (LutSel == 3'd4) ? 5'd4 : 5'd16;
    assign lut_bad = (LutNumShift == 5'd0) ||
                     ({1'b0, LutNumShift} > bits_cap) ||
                     ({3'b0, LutTrailingOnes} > LutTotalCoeff) ||
                     (LutTotalCoeff > tc_max);

    always_comb begin
        state_d = state;
        sel_d   = LutSel;
        bits_d  = LutBits;
        cap_d   = bits_cap;
        cnt_d   = stall_cnt;
        tc_d    = TotalCoeff;
        t1_d    = TrailingOnes;
        err_d   = TokErr;
        amt_d   = 5'd0;
        case (state)
            IDLE: begin
                if (BlkValid && BlkReady) begin
                    sel_d   = sel_new;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (BitsAvail >= MIN_AVAIL) begin
                    bits_d  = Window;
                    cap_d   = BitsAvail;
                    state_d = LOOKUP;
                end else if (stall_cnt == STALL_LAST) begin
                    // starved for STALL_MAX cycles: report an errored token, consume nothing
                    cnt_d   = stall_cnt + 1'b1;
                    tc_d    = 5'd0;
                    t1_d    = 2'd0;
                    err_d   = 1'b1;
                    state_d = EMIT;
                end else begin
                    cnt_d   = stall_cnt + 1'b1;
                end
            end
            LOOKUP: begin
                err_d = lut_bad;
                tc_d  = lut_bad ? 5'd0 : LutTotalCoeff;
                t1_d  = lut_bad ? 2'd0 : LutTrailingOnes;
                if (lut_bad) begin
                    state_d = EMIT;
                end else begin
                    amt_d   = LutNumShift;
                    state_d = SHIFT;
                end
            end
            SHIFT: state_d = EMIT;
            EMIT: begin
                if (TokReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // all outputs are registered from the next state so they are glitch-free and clear in reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            stall_cnt    <= '0;
            bits_cap     <= 6'd0;
            BlkReady     <= 1'b0;
            LutSel       <= 3'd0;
            LutBits      <= 16'd0;
            ShiftValid   <= 1'b0;
            ShiftAmt     <= 5'd0;
            TokValid     <= 1'b0;
            TotalCoeff   <= 5'd0;
            TrailingOnes <= 2'd0;
            TokErr       <= 1'b0;
        end else begin
            state        <= state_d;
            stall_cnt    <= cnt_d;
            bits_cap     <= cap_d;
            BlkReady     <= (state_d == IDLE);
            LutSel       <= sel_d;
            LutBits      <= bits_d;
            ShiftValid   <= (state_d == SHIFT);
            ShiftAmt     <= amt_d;
            TokValid     <= (state_d == EMIT);
            TotalCoeff   <= tc_d;
            TrailingOnes <= t1_d;
            TokErr       <= err_d;
        end
    end

endmodule
